// File: rtl/sdi_pkg.sv
// Shared types and constants for the SDI transmitter.
package sdi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        AUD  = 2'd2
    } sdi_tx_state_e;

    // Word sent in a video slot when no pixel data is offered.
    localparam logic [9:0] BLANK_VIDEO = 10'h040;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdi_piso.sv
// Parallel-in serial-out shifter, LSB first, with registered serial output.
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_word / load_cnt this edge, else shift one bit
//   load_word  : word to serialise (bit 0 goes straight to sdi_out)
//   load_cnt   : bits remaining after the first one
//   sdi_out    : registered serial bit
//   last       : current sdi_out bit is the final bit of its word
module sdi_piso #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             sdi_out,
    output logic             last
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sdi_q, sdi_d;

    // Load or shift; every edge produces a new output bit.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sdi_d   = sdi_q;
        if (load) begin
            sdi_d   = load_word[0];
            shreg_d = load_word >> 1;
            cnt_d   = load_cnt;
        end else begin
            sdi_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            sdi_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sdi_q   <= sdi_d;
        end
    end

    assign sdi_out = sdi_q;
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/sdi_tx.sv
// SDI serial transmitter: frames of AUDIO_PERIOD video slots plus one audio
// slot, filled with blanking / zeros when a source has nothing to send.
//   video_data/valid/ready : pixel word handshake
//   audio_data/valid/ready : audio sample handshake
//   sdi_out                : registered LSB-first serial stream
//   v_sync                 : first bit of a video slot is on sdi_out
//   a_valid                : first bit of a real audio sample is on sdi_out
module sdi_tx
    import sdi_pkg::*;
#(
    parameter int unsigned VIDEO_WIDTH  = 10,
    parameter int unsigned AUDIO_WIDTH  = 16,
    parameter int unsigned AUDIO_PERIOD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [VIDEO_WIDTH-1:0] video_data,
    input  logic                   video_valid,
    output logic                   video_ready,
    input  logic [AUDIO_WIDTH-1:0] audio_data,
    input  logic                   audio_valid,
    output logic                   audio_ready,
    output logic                   sdi_out,
    output logic                   v_sync,
    output logic                   a_valid
);

    localparam int unsigned MAX_W  = max_u(VIDEO_WIDTH, AUDIO_WIDTH);
    localparam int unsigned CNT_W  = $clog2(MAX_W);
    localparam int unsigned SLOT_W = (AUDIO_PERIOD > 1) ? $clog2(AUDIO_PERIOD) : 1;

    sdi_tx_state_e state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;   // index of the current video slot
    logic v_sync_q, v_sync_d;
    logic a_valid_q, a_valid_d;

    logic             last;
    logic             boundary;
    logic             next_is_audio;
    logic [MAX_W-1:0] load_word;
    logic [CNT_W-1:0] load_cnt;

    // Handshakes depend only on state and counters, never on valid.
    assign boundary      = (state_q == IDLE) || last;
    assign next_is_audio = (state_q == VID) && (slot_q == SLOT_W'(AUDIO_PERIOD - 1));
    assign video_ready   = boundary && !next_is_audio;
    assign audio_ready   = boundary && next_is_audio;

    // Word for the next slot, substituting filler when the source is idle.
    always_comb begin
        load_word = '0;
        load_cnt  = CNT_W'(VIDEO_WIDTH - 1);
        if (next_is_audio) begin
            load_word = audio_valid ? MAX_W'(audio_data) : '0;
            load_cnt  = CNT_W'(AUDIO_WIDTH - 1);
        end else begin
            load_word = video_valid ? MAX_W'(video_data)
                                    : MAX_W'(VIDEO_WIDTH'(BLANK_VIDEO));
        end
    end

    // Slot sequencing and frame markers.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        v_sync_d  = 1'b0;
        a_valid_d = 1'b0;
        if (boundary) begin
            if (next_is_audio) begin
                state_d   = AUD;
                slot_d    = '0;
                a_valid_d = audio_valid;
            end else begin
                state_d  = VID;
                v_sync_d = 1'b1;
                slot_d   = (state_q == VID) ? slot_q + SLOT_W'(1) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            v_sync_q  <= 1'b0;
            a_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            v_sync_q  <= v_sync_d;
            a_valid_q <= a_valid_d;
        end
    end

    sdi_piso #(
        .WIDTH (MAX_W),
        .CNT_W (CNT_W)
    ) u_piso (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (boundary),
        .load_word (load_word),
        .load_cnt  (load_cnt),
        .sdi_out   (sdi_out),
        .last      (last)
    );

    assign v_sync  = v_sync_q;
    assign a_valid = a_valid_q;

endmodule

// File: tb/tb_sdi_tx.sv
// Directed bench for sdi_tx: default frame (u0) and AUDIO_PERIOD=1 (u1).
module tb_sdi_tx;

    logic        clk;
    logic        rst_n;
    logic [9:0]  video_data;
    logic        video_valid;
    logic        video_ready;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        audio_ready;
    logic        sdi_out;
    logic        v_sync;
    logic        a_valid;

    logic [9:0]  v1_data;
    logic        v1_valid;
    logic        v1_ready;
    logic [15:0] a1_data;
    logic        a1_valid;
    logic        a1_ready;
    logic        sdi1;
    logic        vs1;
    logic        av1;

    int n_checks;
    int n_errors;
    int cur_p;

    sdi_tx u0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .video_data  (video_data),
        .video_valid (video_valid),
        .video_ready (video_ready),
        .audio_data  (audio_data),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .sdi_out     (sdi_out),
        .v_sync      (v_sync),
        .a_valid     (a_valid)
    );

    sdi_tx #(.AUDIO_PERIOD(1)) u1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .video_data  (v1_data),
        .video_valid (v1_valid),
        .video_ready (v1_ready),
        .audio_data  (a1_data),
        .audio_valid (a1_valid),
        .audio_ready (a1_ready),
        .sdi_out     (sdi1),
        .v_sync      (vs1),
        .a_valid     (av1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s p=%0d got=%0b exp=%0b", tag, cur_p, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks ncyc cycles of a default frame; vw holds slots 3..0, 10 bits each.
    task automatic run_frame(input logic [39:0] vw, input logic [15:0] aw,
                             input bit areal, input int ncyc, input bit inject);
        logic e_sdi, e_vs, e_av, e_vr, e_ar;
        int s, b;
        for (int p = 0; p < ncyc; p++) begin
            tick();
            cur_p = p;
            if (p < 40) begin
                s     = p / 10;
                b     = p % 10;
                e_sdi = vw[s*10 + b];
                e_vs  = (b == 0);
                e_av  = 1'b0;
                e_vr  = (b == 9) && (s != 3);
                e_ar  = (b == 9) && (s == 3);
            end else begin
                b     = p - 40;
                e_sdi = areal ? aw[b] : 1'b0;
                e_vs  = 1'b0;
                e_av  = areal && (b == 0);
                e_vr  = (b == 15);
                e_ar  = 1'b0;
            end
            check("sdi_out", sdi_out, e_sdi);
            check("v_sync", v_sync, e_vs);
            check("a_valid", a_valid, e_av);
            check("video_ready", video_ready, e_vr);
            check("audio_ready", audio_ready, e_ar);
            if (inject && p == 3) begin
                video_valid = 1'b1;
                video_data  = 10'h155;
            end
            if (inject && p == 10) video_valid = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] beef;
        logic [9:0]  w3a5;
        logic        e_sdi;
        int q;
        n_checks    = 0;
        n_errors    = 0;
        cur_p       = -1;
        beef        = 16'hBEEF;
        w3a5        = 10'h3A5;
        rst_n       = 1'b0;
        video_data  = 10'h3A5;
        video_valid = 1'b0;
        audio_data  = 16'hBEEF;
        audio_valid = 1'b0;
        v1_data     = 10'h3A5;
        v1_valid    = 1'b1;
        a1_data     = 16'hBEEF;
        a1_valid    = 1'b1;

        tick(); tick(); tick();
        check("rst_sdi_out", sdi_out, 1'b0);
        check("rst_v_sync", v_sync, 1'b0);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_video_ready", video_ready, 1'b1);
        check("rst_audio_ready", audio_ready, 1'b0);

        // Video held valid, no audio: two identical frames.
        video_valid = 1'b1;
        rst_n       = 1'b1;
        check("idle_video_ready", video_ready, 1'b1);
        check("idle_audio_ready", audio_ready, 1'b0);
        run_frame({4{10'h3A5}}, 16'h0000, 1'b0, 56, 1'b0);
        run_frame({4{10'h3A5}}, 16'h0000, 1'b0, 56, 1'b0);

        // No video: blanking words.
        video_valid = 1'b0;
        run_frame({4{10'h040}}, 16'h0000, 1'b0, 56, 1'b0);

        // Real audio sample.
        video_valid = 1'b1;
        audio_valid = 1'b1;
        run_frame({4{10'h3A5}}, 16'hBEEF, 1'b1, 56, 1'b0);
        audio_valid = 1'b0;

        // Video goes valid mid-slot: lands in slot 1 only.
        video_valid = 1'b0;
        run_frame({10'h040, 10'h040, 10'h155, 10'h040}, 16'h0000, 1'b0, 56, 1'b1);

        // Reset in the middle of an audio slot.
        video_valid = 1'b1;
        video_data  = 10'h3A5;
        audio_valid = 1'b1;
        run_frame({4{10'h3A5}}, 16'hBEEF, 1'b1, 46, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_sdi_out", sdi_out, 1'b0);
        check("midrst_v_sync", v_sync, 1'b0);
        check("midrst_a_valid", a_valid, 1'b0);
        check("midrst_audio_ready", audio_ready, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        check("rel_video_ready", video_ready, 1'b1);
        check("rel_audio_ready", audio_ready, 1'b0);
        run_frame({4{10'h3A5}}, 16'hBEEF, 1'b1, 56, 1'b0);

        // AUDIO_PERIOD=1: alternate video/audio, 26-cycle period.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("ap1_idle_video_ready", v1_ready, 1'b1);
        for (int p = 0; p < 52; p++) begin
            tick();
            cur_p = p;
            q = p % 26;
            e_sdi = (q < 10) ? w3a5[q] : beef[q-10];
            check("ap1_sdi_out", sdi1, e_sdi);
            check("ap1_v_sync", vs1, q == 0);
            check("ap1_a_valid", av1, q == 10);
            check("ap1_video_ready", v1_ready, q == 25);
            check("ap1_audio_ready", a1_ready, q == 9);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdi_tx.md
# sdi_tx

Serial transmitter for the SDI link. Accepts parallel video words and audio samples over valid/ready handshakes and emits one continuous LSB-first bit stream, one bit per `clk`. Stream is a repeating frame: `AUDIO_PERIOD` video slots followed by one audio slot. When a source has no data, the video slot carries a blanking word and the audio slot carries zeros, so receive-side framing never stalls. Sits at the egress end of the link, feeding the serializer pin or loopback path.

## Interface
- `VIDEO_WIDTH`, 10, bits per video word; must be ≥2.
- `AUDIO_WIDTH`, 16, bits per audio sample; must be ≥2.
- `AUDIO_PERIOD`, 4, video slots per audio slot; must be ≥1.
- `clk` in 1 — single clock; every port is synchronous to its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `video_data` in `VIDEO_WIDTH` — pixel word.
- `video_valid` in 1 — `video_data` is valid.
- `video_ready` out 1 — word accepted on the edge where valid & ready.
- `audio_data` in `AUDIO_WIDTH` — audio sample.
- `audio_valid` in 1 — `audio_data` is valid.
- `audio_ready` out 1 — sample accepted on the edge where valid & ready.
- `sdi_out` out 1 — serial output, registered.
- `v_sync` out 1 — high on the cycle the first bit of any video slot (real or blanking) is on `sdi_out`.
- `a_valid` out 1 — high on the cycle the first bit of an audio slot carrying a real sample is on `sdi_out`.

## Operation
- FSM states: IDLE, VID, AUD. Counters:
  - `cnt`: bits still to drive after the current bit; `$clog2(max(VIDEO_WIDTH, AUDIO_WIDTH))` bits.
  - `slot`: video slots sent in the current frame, 0..`AUDIO_PERIOD`-1.
- The boundary cycle is when state is IDLE or `cnt==0`.
- The next slot is audio when state is VID and `slot==AUDIO_PERIOD-1`; otherwise it is video.
- `video_ready` = boundary & next slot is video.
- `audio_ready` = boundary & next slot is audio.
- Both ready signals are combinational from state and counters only. They must never depend on the valid inputs.
- Load edge (end of a boundary cycle):
  - Select the word:
    - Video slot: `video_data` if `video_valid`, else `BLANK_VIDEO` (0x040, zero-extended/truncated to `VIDEO_WIDTH`).
    - Audio slot: `audio_data` if `audio_valid`, else all zeros.
  - Registered updates: `sdi_out` ← word[0]; shift register ← word>>1; `cnt` ← width-1; state ← VID or AUD.
  - `v_sync` ← 1 for a video slot. `a_valid` ← 1 only for an audio slot loaded with a real sample.
  - `slot`: increments on each video load; clears on each audio load.
- Non-boundary edge: `sdi_out` ← shreg[0]; shreg >>= 1; `cnt`--; `v_sync`, `a_valid` ← 0.
- Frame length: `AUDIO_PERIOD*VIDEO_WIDTH + AUDIO_WIDTH` cycles (56 with defaults). Once out of IDLE, the stream has no gaps.
- A source that goes valid mid-slot waits, holding its data stable, until its next ready. An audio sample that misses its audio boundary waits a full frame.
- Reset mid-operation drops the partial word. An accepted word is never retransmitted. After reset the first slot is video and `slot`=0.

## Timing
- Reset values:
  - `sdi_out`=0, `v_sync`=0, `a_valid`=0, state=IDLE, `cnt`=0, `slot`=0, shreg=0.
  - `video_ready`=1 during IDLE. `audio_ready`=0.
- IDLE lasts exactly the first cycle after `rst_n` deasserts.
- Latency: a word accepted at edge N drives bit 0 on `sdi_out` in cycle N+1, with `v_sync`/`a_valid` in that same cycle. Bit k appears in cycle N+1+k.
- The ready signal is high in the last-bit cycle of the previous slot, which gives back-to-back slots.

## Structure
- Package `sdi_pkg`: state enum `sdi_tx_state_e` {IDLE, VID, AUD} and constant `BLANK_VIDEO` = 10'h040.
- Sub-module `sdi_piso`, parameterized to `max(VIDEO_WIDTH, AUDIO_WIDTH)`. It contains the shift register, `cnt`, the load/shift logic and the registered `sdi_out`, and outputs `last`. The FSM, slot counter and handshakes stay in `sdi_tx`.

## Test plan
- Defaults; `video_data`=0x3A5 held valid; `audio_valid`=0.
  - Each video slot drives `sdi_out` 1,0,1,0,0,1,0,1,1,1, with `v_sync` on the first bit.
  - After 4 slots, 16 zero cycles with `a_valid`=0; frame repeats every 56 cycles.
- `video_valid`=0 throughout.
  - Each video slot drives 0,0,0,0,0,0,1,0,0,0; `v_sync` still pulses every 10 cycles in the video region.
  - `video_ready` pulses but nothing is consumed.
- `audio_data`=0xBEEF held valid.
  - `audio_ready` high exactly one cycle (last bit of 4th video slot).
  - Next 16 bits are 0xBEEF LSB-first (1,1,1,1,0,1,1,1,0,1,1,1,1,1,0,1); `a_valid` on the first of them.
- Assert `video_valid` with 0x155 in the 4th cycle of a slot.
  - `video_ready` low until the slot's last bit; accepted exactly once.
  - 0x155 bits begin the following cycle.
- Pulse `rst_n` low mid-audio-slot.
  - `sdi_out`/`v_sync`/`a_valid` go 0 immediately; `video_ready`=1 in the first cycle after release.
  - 4 video slots precede the next audio slot.
- `AUDIO_PERIOD`=1, both sources always valid.
  - Slots strictly alternate video/audio; period 26 cycles; ready pulses alternate.
